// File: rtl/lt24_pkg.sv
// Shared types and constants for the LT24 8080-style LCD write controller.
// Register map, control/status bit positions and the strobe FSM state encoding.
package lt24_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WRL,
    ST_WRH
  } lt24_state_e;

  localparam logic [1:0] ADDR_CMD  = 2'd0;
  localparam logic [1:0] ADDR_DATA = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_FILL = 2'd3;

  localparam int CTRL_LCD_RESET = 0;
  localparam int CTRL_IRQ_EN    = 1;
  localparam int CTRL_IRQ_CLEAR = 2;

  localparam int STAT_BUSY      = 16;
  localparam int STAT_FILL      = 17;
  localparam int STAT_IRQ_EN    = 18;
  localparam int STAT_IRQ       = 19;
  localparam int STAT_LCD_RESET = 20;

  // Phase timer width; each strobe phase may last up to 256 cycles.
  localparam int TIMER_W = 8;

  function automatic logic [TIMER_W-1:0] last_tick(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/lt24_lcd_writer_if.sv
// Avalon-MM slave bundle for the LT24 writer: the host drives the master side,
// the controller implements the slave side.
interface lt24_lcd_writer_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output address, write, writedata, read,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, write, writedata, read,
    output readdata, waitrequest
  );
endinterface

// File: rtl/lt24_fifo.sv
// Synchronous show-ahead FIFO with full/empty flags and an occupancy count.
// Push while full and pop while empty are ignored.
module lt24_fifo #(
  parameter  int WIDTH = 17,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; entries are only ever read behind the
  // level count, and a reset-free array can map onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

endmodule

// File: rtl/lt24_lcd_writer.sv
// Write-only Avalon-MM controller for the LT24 8080 parallel LCD bus: command/data
// FIFO, programmable strobe timing, hardware pixel-fill repeat, panel reset and done IRQ.
module lt24_lcd_writer
  import lt24_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int T_SETUP    = 1,
  parameter int T_WRL      = 2,
  parameter int T_WRH      = 2,
  parameter int REPEAT_W   = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  lt24_lcd_writer_if.slave  avs,
  output logic              lt24_cs,
  output logic              lt24_rd,
  output logic              lt24_wr,
  output logic              lt24_rs,
  output logic [DATA_W-1:0] lt24_data,
  output logic              lcd_reset_n,
  output logic              irq
);

  localparam int WORD_W  = DATA_W + 1;
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TIMER_W-1:0] SETUP_LAST = last_tick(T_SETUP);
  localparam logic [TIMER_W-1:0] WRL_LAST   = last_tick(T_WRL);
  localparam logic [TIMER_W-1:0] WRH_LAST   = last_tick(T_WRH);

  lt24_state_e          state;
  logic [TIMER_W-1:0]   timer;
  logic [REPEAT_W-1:0]  fill_count;
  logic [DATA_W-1:0]    last_word;
  logic [DATA_W-1:0]    next_data;
  logic                 next_rs;
  logic                 cur_fill;
  logic                 irq_en;
  logic                 irq_flag;
  logic [31:0]          status;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WORD_W-1:0]    fifo_word;
  logic [LEVEL_W-1:0]   fifo_level;

  logic wr_queue, wr_ctrl, wr_fill;
  logic fill_ready, fill_accept, fill_pending;
  logic next_ready, phase_done, start_word, done_evt;

  // Address decode and stall rules
  assign wr_queue     = avs.write && !avs.address[1];
  assign wr_ctrl      = avs.write && (avs.address == ADDR_CTRL);
  assign wr_fill      = avs.write && (avs.address == ADDR_FILL);
  assign fill_pending = (fill_count != '0);
  assign fill_ready   = fifo_empty && (state == ST_IDLE) && !fill_pending;
  assign fill_accept  = wr_fill && fill_ready;
  assign fifo_push    = wr_queue && !fifo_full;

  assign avs.waitrequest = (wr_queue && fifo_full) || (wr_fill && !fill_ready);

  lt24_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data ({avs.address[0], avs.writedata[DATA_W-1:0]}),
    .pop       (fifo_pop),
    .pop_data  (fifo_word),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // A pending fill outranks queued words, so queued writes go out after it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    phase_done = 1'b0;
    next_rs    = fifo_word[DATA_W];
    next_data  = fifo_word[DATA_W-1:0];
    if (fill_pending) begin
      next_rs   = 1'b1;
      next_data = last_word;
    end
    case (state)
      ST_SETUP: phase_done = (timer == SETUP_LAST);
      ST_WRL:   phase_done = (timer == WRL_LAST);
      ST_WRH:   phase_done = (timer == WRH_LAST);
      default:  phase_done = 1'b0;
    endcase
  end

  assign next_ready = fill_pending || !fifo_empty;
  assign start_word = next_ready &&
                      ((state == ST_IDLE) || ((state == ST_WRH) && phase_done));
  assign fifo_pop   = start_word && !fill_pending;
  assign done_evt   = (state == ST_WRH) && phase_done && !next_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      timer     <= '0;
      lt24_cs   <= 1'b1;
      lt24_wr   <= 1'b1;
      lt24_rs   <= 1'b0;
      lt24_data <= '0;
      last_word <= '0;
      cur_fill  <= 1'b0;
    end else begin
      timer <= (phase_done || state == ST_IDLE) ? '0 : timer + 1'b1;
      if (start_word) begin
        lt24_data <= next_data;
        lt24_rs   <= next_rs;
        cur_fill  <= fill_pending;
        if (!fill_pending && next_rs) last_word <= next_data;
      end
      case (state)
        ST_IDLE: begin
          if (start_word) begin
            state   <= ST_SETUP;
            lt24_cs <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (phase_done) begin
            state   <= ST_WRL;
            lt24_wr <= 1'b0;
          end
        end
        ST_WRL: begin
          if (phase_done) begin
            state   <= ST_WRH;
            lt24_wr <= 1'b1;
          end
        end
        ST_WRH: begin
          // Back-to-back words keep cs low across the word boundary.
          if (phase_done) begin
            if (start_word) begin
              state <= ST_SETUP;
            end else begin
              state    <= ST_IDLE;
              lt24_cs  <= 1'b1;
              cur_fill <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_count <= '0;
    end else if (fill_accept) begin
      fill_count <= avs.writedata[REPEAT_W-1:0];
    end else if (start_word && fill_pending) begin
      fill_count <= fill_count - 1'b1;
    end
  end

  // A clear written in the same cycle as a done event wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lcd_reset_n <= 1'b0;
      irq_en      <= 1'b0;
      irq_flag    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        lcd_reset_n <= avs.writedata[CTRL_LCD_RESET];
        irq_en      <= avs.writedata[CTRL_IRQ_EN];
      end
      if (wr_ctrl && avs.writedata[CTRL_IRQ_CLEAR]) irq_flag <= 1'b0;
      else if (done_evt)                             irq_flag <= 1'b1;
    end
  end

  assign irq     = irq_flag && irq_en;
  assign lt24_rd = 1'b1;

  always_comb begin
    status                 = '0;
    status[15:0]           = 16'(fifo_level);
    status[STAT_BUSY]      = (state != ST_IDLE);
    status[STAT_FILL]      = fill_pending || cur_fill;
    status[STAT_IRQ_EN]    = irq_en;
    status[STAT_IRQ]       = irq_flag;
    status[STAT_LCD_RESET] = lcd_reset_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs.readdata <= '0;
    end else if (avs.read && avs.address == ADDR_CTRL) begin
      avs.readdata <= status;
    end else begin
      avs.readdata <= '0;
    end
  end

endmodule

// File: tb/tb_lt24_lcd_writer.sv
// Self-checking bench for lt24_lcd_writer: a bus monitor records every wr pulse and
// a queue model of the expected word stream is built from the register writes.
module tb_lt24_lcd_writer;
  import lt24_pkg::*;

  localparam int T_WORD = 5;   // T_SETUP + T_WRL + T_WRH
  localparam int T_LOW  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lt24_cs, lt24_rd, lt24_wr, lt24_rs;
  logic [15:0] lt24_data;
  logic        lcd_reset_n, irq;

  lt24_lcd_writer_if avs ();

  lt24_lcd_writer #(
    .DATA_W(16), .FIFO_DEPTH(16), .T_SETUP(1), .T_WRL(2), .T_WRH(2), .REPEAT_W(17)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .avs         (avs),
    .lt24_cs     (lt24_cs),
    .lt24_rd     (lt24_rd),
    .lt24_wr     (lt24_wr),
    .lt24_rs     (lt24_rs),
    .lt24_data   (lt24_data),
    .lcd_reset_n (lcd_reset_n),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle++;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: expected bus words in order, plus the last pixel word sent.
  typedef struct packed { logic rs; logic [15:0] data; } word_t;
  word_t       exp_q[$];
  logic [15:0] model_last = '0;

  function automatic void model_enqueue(input logic rs, input logic [15:0] d);
    exp_q.push_back({rs, d});
    if (rs) model_last = d;
  endfunction

  function automatic void model_fill(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, model_last});
  endfunction

  // Bus monitor, sampled on the falling clock edge.
  typedef struct { logic rs; logic [15:0] data; int low; int fall_cycle; bit cs_gap; bit cs_low; } obs_t;
  obs_t obs_q[$];
  obs_t cur;
  bit   in_pulse = 0;
  bit   cs_seen_high = 1;
  logic prev_wr = 1'b1;

  always @(negedge clk) begin
    if (!reset_n) begin
      in_pulse = 0; prev_wr = 1'b1; cs_seen_high = 1;
    end else begin
      if (lt24_cs) cs_seen_high = 1;
      if (prev_wr && !lt24_wr) begin
        cur.rs = lt24_rs; cur.data = lt24_data; cur.low = 1; cur.fall_cycle = cycle;
        cur.cs_gap = cs_seen_high; cur.cs_low = !lt24_cs;
        cs_seen_high = 0; in_pulse = 1;
      end else if (!lt24_wr && in_pulse) begin
        cur.low++;
      end else if (lt24_wr && in_pulse) begin
        obs_q.push_back(cur);
        in_pulse = 0;
      end
      prev_wr = lt24_wr;
    end
  end

  // Bus access helpers; all enter and leave 1 time unit after a rising edge.
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] wdata, output int stalls);
    stalls = 0;
    avs.address = addr; avs.writedata = wdata; avs.write = 1'b1;
    forever begin
      @(negedge clk);
      if (!avs.waitrequest) break;
      stalls++;
      if (stalls > 2000) begin
        n_checks++; n_fail++;
        $display("FAIL bus_write_timeout addr=%0d stalled %0d cycles, required < 2000", addr, stalls);
        break;
      end
    end
    @(posedge clk); #1;
    avs.write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] rdata);
    avs.address = addr; avs.read = 1'b1;
    @(posedge clk); #1;
    avs.read = 1'b0;
    rdata = avs.readdata;
  endtask

  task automatic wait_idle();
    logic [31:0] st;
    int i;
    for (i = 0; i < 3000; i++) begin
      bus_read(ADDR_CTRL, st);
      if (!st[STAT_BUSY] && !st[STAT_FILL] && st[15:0] == 16'd0) break;
    end
    if (i == 3000) begin
      n_checks++; n_fail++;
      $display("FAIL wait_idle_timeout status=%h after %0d reads, required idle", st, i);
    end
  endtask

  task automatic compare_stream(input string name);
    int n;
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_count observed %0d words, required %0d", name, obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_checks++;
      if (obs_q[i].rs !== exp_q[i].rs || obs_q[i].data !== exp_q[i].data) begin
        n_fail++;
        $display("FAIL %s_word[%0d] got rs=%b data=%h, required rs=%b data=%h",
                 name, i, obs_q[i].rs, obs_q[i].data, exp_q[i].rs, exp_q[i].data);
      end
      n_checks++;
      if (obs_q[i].low != T_LOW || !obs_q[i].cs_low) begin
        n_fail++;
        $display("FAIL %s_strobe[%0d] got wr_low=%0d cs_low=%0b, required wr_low=%0d cs_low=1",
                 name, i, obs_q[i].low, obs_q[i].cs_low, T_LOW);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] st;
    #23;
    n_checks++;
    if ({lt24_cs, lt24_rd, lt24_wr, lt24_rs} !== 4'b1110) begin
      n_fail++; $display("FAIL reset_strobes got cs,rd,wr,rs=%b, required 1110", {lt24_cs, lt24_rd, lt24_wr, lt24_rs});
    end
    n_checks++;
    if (lt24_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_data got %h, required 0000", lt24_data);
    end
    n_checks++;
    if ({lcd_reset_n, irq, avs.waitrequest} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl got lcd_reset_n,irq,waitrequest=%b, required 000", {lcd_reset_n, irq, avs.waitrequest});
    end
    n_checks++;
    if (avs.readdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_readdata got %h, required 0", avs.readdata);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    bus_read(ADDR_CTRL, st);
    n_checks++;
    if (st !== 32'h0) begin
      n_fail++; $display("FAIL reset_status got %h, required 0", st);
    end
  endtask

  task automatic test_cmd_data();
    int s;
    logic [31:0] st;
    bus_write(ADDR_CMD, 32'h0000_002C, s);  model_enqueue(1'b0, 16'h002C);
    bus_write(ADDR_DATA, 32'h0000_F800, s); model_enqueue(1'b1, 16'hF800);
    wait_idle();
    n_checks++;
    if (obs_q.size() == 2) begin
      if (obs_q[1].cs_gap || (obs_q[1].fall_cycle - obs_q[0].fall_cycle) != T_WORD) begin
        n_fail++;
        $display("FAIL cmd_data_spacing got cs_gap=%0b period=%0d, required cs_gap=0 period=%0d",
                 obs_q[1].cs_gap, obs_q[1].fall_cycle - obs_q[0].fall_cycle, T_WORD);
      end
    end else begin
      n_fail++; $display("FAIL cmd_data_pulses got %0d, required 2", obs_q.size());
    end
    compare_stream("cmd_data");
    bus_read(ADDR_CTRL, st);
    n_checks++;
    if (st !== 32'h0008_0000 || irq !== 1'b0) begin
      n_fail++; $display("FAIL cmd_data_done got status=%h irq=%b, required status=00080000 irq=0", st, irq);
    end
  endtask

  task automatic test_back_to_back();
    int s, early_stalls, last_stalls;
    logic [15:0] w0, d;
    w0 = 16'($urandom);
    bus_write(ADDR_DATA, {16'($urandom), w0}, s); model_enqueue(1'b1, w0);
    wait_idle();
    bus_write(ADDR_FILL, 32'd20, s); model_fill(20);
    n_checks++;
    if (s != 0) begin
      n_fail++; $display("FAIL b2b_fill_accept got %0d stall cycles, required 0", s);
    end
    early_stalls = 0;
    last_stalls = 0;
    for (int i = 0; i < 17; i++) begin
      d = 16'($urandom);
      bus_write(ADDR_DATA, {16'($urandom), d}, s); model_enqueue(1'b1, d);
      if (i < 16) early_stalls += s;
      else        last_stalls = s;
    end
    n_checks++;
    if (early_stalls != 0) begin
      n_fail++; $display("FAIL b2b_first16 got %0d stall cycles, required 0", early_stalls);
    end
    n_checks++;
    if (last_stalls == 0) begin
      n_fail++; $display("FAIL b2b_17th got %0d stall cycles, required > 0", last_stalls);
    end
    wait_idle();
    compare_stream("b2b");
  endtask

  task automatic test_fill();
    int s;
    logic [31:0] st;
    bus_write(ADDR_CTRL, 32'h7, s);
    n_checks++;
    if (irq !== 1'b0 || s != 0) begin
      n_fail++; $display("FAIL fill_clear got irq=%b stalls=%0d, required irq=0 stalls=0", irq, s);
    end
    bus_write(ADDR_DATA, 32'h0000_07E0, s); model_enqueue(1'b1, 16'h07E0);
    bus_write(ADDR_FILL, 32'd5, s);         model_fill(5);
    n_checks++;
    if (s == 0) begin
      n_fail++; $display("FAIL fill_wait got %0d stall cycles, required > 0", s);
    end
    wait_idle();
    compare_stream("fill");
    bus_read(ADDR_CTRL, st);
    n_checks++;
    if (st !== 32'h001C_0000 || irq !== 1'b1 || lcd_reset_n !== 1'b1) begin
      n_fail++; $display("FAIL fill_done got status=%h irq=%b lcd_reset_n=%b, required 001c0000 1 1", st, irq, lcd_reset_n);
    end
    bus_write(ADDR_CTRL, 32'h7, s);
    bus_write(ADDR_FILL, 32'd0, s);
    n_checks++;
    if (s != 0) begin
      n_fail++; $display("FAIL fill_zero_accept got %0d stall cycles, required 0", s);
    end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL fill_zero got %0d pulses irq=%b, required 0 pulses irq=0", obs_q.size(), irq);
    end
  endtask

  task automatic test_random();
    int s, k, n;
    logic [1:0]  a;
    logic [31:0] d;
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(1, 5);
      for (int i = 0; i < k; i++) begin
        a = 2'($urandom_range(0, 1)); d = $urandom;
        bus_write(a, d, s); model_enqueue(a[0], d[15:0]);
      end
      n = $urandom_range(0, 6);
      bus_write(ADDR_FILL, ($urandom << 17) | 32'(n), s); model_fill(n);
      k = $urandom_range(0, 3);
      for (int i = 0; i < k; i++) begin
        a = 2'($urandom_range(0, 1)); d = $urandom;
        bus_write(a, d, s); model_enqueue(a[0], d[15:0]);
      end
      wait_idle();
      compare_stream("random");
    end
  endtask

  task automatic test_irq_clear_race();
    int s;
    logic [31:0] st;
    bus_write(ADDR_CTRL, 32'h7, s);
    bus_write(ADDR_CMD, 32'h0000_0029, s); model_enqueue(1'b0, 16'h0029);
    // One cycle to leave IDLE, then one word period until the done event.
    repeat (T_WORD) @(posedge clk);
    #1;
    bus_write(ADDR_CTRL, 32'h7, s);
    n_checks++;
    if (s != 0 || irq !== 1'b0) begin
      n_fail++; $display("FAIL race_irq got stalls=%0d irq=%b, required 0 0", s, irq);
    end
    repeat (3) @(posedge clk);
    #1;
    bus_read(ADDR_CTRL, st);
    n_checks++;
    if (st !== 32'h0014_0000 || irq !== 1'b0) begin
      n_fail++; $display("FAIL race_status got status=%h irq=%b, required 00140000 irq=0", st, irq);
    end
    compare_stream("race");
  endtask

  task automatic test_reset_mid_strobe();
    int s, i;
    logic [31:0] st;
    bus_write(ADDR_CTRL, 32'h1, s);
    for (int j = 0; j < 3; j++) bus_write(ADDR_DATA, $urandom, s);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!lt24_wr) break;
    end
    n_checks++;
    if (i == 50) begin
      n_fail++; $display("FAIL rst_mid_wait got no wr pulse in %0d cycles, required one", i);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (lt24_wr !== 1'b1 || lt24_cs !== 1'b1 || lcd_reset_n !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs got wr=%b cs=%b lcd_reset_n=%b, required 1 1 0", lt24_wr, lt24_cs, lcd_reset_n);
    end
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    obs_q.delete(); exp_q.delete(); model_last = '0;
    bus_read(ADDR_CTRL, st);
    n_checks++;
    if (st !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_status got %h, required 0", st);
    end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (obs_q.size() != 0) begin
      n_fail++; $display("FAIL rst_mid_drain got %0d pulses after reset, required 0", obs_q.size());
    end
  endtask

  initial begin
    avs.address = '0; avs.write = 1'b0; avs.writedata = '0; avs.read = 1'b0;
    test_reset();
    test_cmd_data();
    test_back_to_back();
    test_fill();
    test_random();
    test_irq_clear_race();
    test_reset_mid_strobe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog simulation exceeded 50000 cycles, required completion");
    $fatal(1, "watchdog");
  end

endmodule
